// File: rtl/div3_rr_scheduler.sv
// rtl/div3_rr_scheduler.sv - round-robin front end sharing one bit-serial mod-3 residue engine
module div3_rr_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] data,
   input  logic                  hold,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  ser_vld,
   output logic                  ser_bit,
   output logic                  done,
   output logic [IDW-1:0]        done_id,
   output logic                  div3,
   output logic [1:0]            residue
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sh;
   logic [CW-1:0]    cnt;
   logic [1:0]       r, r_nxt;
   logic [IDW-1:0]   ptr;
   logic [NREQ-1:0]  gnt_q;
   logic             win_found;
   logic [IDW-1:0]   win_idx;
   logic [IDW:0]     cand;
   logic             shift_en;

   // Walk downward so the candidate closest to ptr+1 is the last one written.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = {1'b0, ptr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ))
            cand = cand - (IDW+1)'(NREQ);
         if (req[cand[IDW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IDW-1:0];
         end
      end
   end

   assign shift_en = (state == S_SHIFT) && !hold;

   always_comb begin
      r_nxt = 2'd0;
      case (r)
         2'd0:    r_nxt = sh[WIDTH-1] ? 2'd1 : 2'd0;
         2'd1:    r_nxt = sh[WIDTH-1] ? 2'd0 : 2'd2;
         2'd2:    r_nxt = sh[WIDTH-1] ? 2'd2 : 2'd1;
         default: r_nxt = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         sh    <= '0;
         cnt   <= '0;
         r     <= 2'd0;
         ptr   <= IDW'(NREQ - 1);
         gnt_q <= '0;
      end else begin
         state <= state_nxt;
         gnt_q <= ((state == S_IDLE) && win_found) ? (NREQ'(1) << win_idx) : '0;
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  sh  <= data[win_idx*WIDTH +: WIDTH];
                  cnt <= CW'(WIDTH);
                  r   <= 2'd0;
                  ptr <= win_idx;
               end
            end
            S_SHIFT: begin
               if (shift_en) begin
                  sh  <= {sh[WIDTH-2:0], 1'b0};
                  cnt <= cnt - CW'(1);
                  r   <= r_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (win_found) state_nxt = S_SHIFT;
         S_SHIFT: if (shift_en && (cnt == CW'(1))) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ptr doubles as the job's ID: it is only rewritten at the next arbitration.
   always_comb begin
      gnt     = gnt_q;
      busy    = (state != S_IDLE);
      ser_vld = shift_en;
      ser_bit = shift_en & sh[WIDTH-1];
      done    = (state == S_DONE);
      done_id = done ? ptr : '0;
      residue = done ? r : 2'd0;
      div3    = done && (r == 2'd0);
   end

endmodule

// File: tb/tb_div3_rr_scheduler.sv
// tb/tb_div3_rr_scheduler.sv - self-checking bench for div3_rr_scheduler
module tb_div3_rr_scheduler;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data;
   logic                  hold;
   logic [NREQ-1:0]       gnt;
   logic                  busy, ser_vld, ser_bit, done, div3;
   logic [IDW-1:0]        done_id;
   logic [1:0]            residue;

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;
   int ptr_m = NREQ - 1;

   div3_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .hold(hold),
      .gnt(gnt), .busy(busy), .ser_vld(ser_vld), .ser_bit(ser_bit),
      .done(done), .done_id(done_id), .div3(div3), .residue(residue)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [NREQ-1:0]       mask;
      logic [NREQ*WIDTH-1:0] dat;
      int                    exp_id;
      int                    exp_res;
      int                    exp_lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int rr_pick(input int p, input logic [NREQ-1:0] m);
      for (int k = 1; k <= NREQ; k++)
         if (m[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [NREQ*WIDTH-1:0] rand_data();
      logic [NREQ*WIDTH-1:0] d;
      for (int i = 0; i < NREQ; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      return d;
   endfunction

   // Called at the start of an IDLE cycle; returns one cycle into the next IDLE.
   task automatic run_job(input logic [NREQ-1:0] mask, input logic [NREQ*WIDTH-1:0] dat,
                          input logic [63:0] hpat, output int win, output int res,
                          output int lat, output int gcyc);
      int exp_win, nbits, nheld, c, expd;
      logic [WIDTH-1:0] word;
      exp_win = rr_pick(ptr_m, mask);
      word    = dat[exp_win*WIDTH +: WIDTH];
      expd    = word % 3;
      req = mask; data = dat; hold = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_gnt", gnt, 0);
      tick();
      c = 0; nbits = 0; nheld = 0; gcyc = 0;
      while (nbits < WIDTH && c < 64) begin
         hold = hpat[c];
         if (c > 0) begin
            req  = NREQ'($urandom);
            data = rand_data();
         end
         @(negedge clk);
         if (c == 0) gcyc = cyc;
         chk("shift_gnt", gnt, (c == 0) ? (32'd1 << exp_win) : 32'd0);
         chk("shift_busy", busy, 1);
         chk("shift_vld", ser_vld, !hold);
         chk("shift_bit", ser_bit, hold ? 1'b0 : word[WIDTH-1-nbits]);
         chk("shift_quiet", {done, done_id, residue, div3}, 0);
         if (hold) nheld++; else nbits++;
         c++;
         tick();
      end
      chk("shift_bits", nbits, WIDTH);
      hold = 1'($urandom);
      @(negedge clk);
      chk("done", done, 1);
      chk("done_gnt", gnt, 0);
      chk("done_vld", ser_vld, 0);
      chk("done_res", residue, expd);
      chk("done_div3", div3, expd == 0);
      chk("done_id", done_id, exp_win);
      lat = cyc - gcyc;
      chk("done_lat", lat, WIDTH + nheld);
      win = done_id;
      res = residue;
      ptr_m = exp_win;
      req = '0; hold = 1'b0;
      tick();
   endtask

   vec_t vt[7];
   int   exp_ord[6];
   int   w, rs, lat, gc, gprev;
   logic [63:0] hp;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{4'b0001, 32'd21,        0, 0, 8};
      vt[1] = '{4'b0100, 32'd100 << 16, 2, 1, 8};
      vt[2] = '{4'b0100, 32'd5   << 16, 2, 2, 8};
      vt[3] = '{4'b0100, 32'd255 << 16, 2, 0, 8};
      vt[4] = '{4'b0100, 32'd0,         2, 0, 8};
      vt[5] = '{4'b1000, 32'd7   << 24, 3, 1, 8};
      vt[6] = '{4'b0010, 32'd128 << 8,  1, 2, 8};
      exp_ord = '{0, 1, 2, 3, 0, 1};

      rst = 1'b1; req = '0; data = '0; hold = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_outs", {gnt, busy, ser_vld, ser_bit, done, done_id, div3, residue}, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_idle", {gnt, busy, done}, 0);
      tick();

      // full contention straight after reset: requester 0 first
      gprev = 0;
      for (int i = 0; i < 6; i++) begin
         run_job(4'hF, rand_data(), 64'd0, w, rs, lat, gc);
         chk("cont_order", w, exp_ord[i]);
         if (i > 0) chk("cont_spacing", gc - gprev, WIDTH + 2);
         gprev = gc;
      end

      for (int i = 0; i < 7; i++) begin
         run_job(vt[i].mask, vt[i].dat, 64'd0, w, rs, lat, gc);
         chk("tbl_id", w, vt[i].exp_id);
         chk("tbl_res", rs, vt[i].exp_res);
         chk("tbl_lat", lat, vt[i].exp_lat);
      end

      // hold for 3 cycles after the 4th bit
      run_job(4'b0100, 32'd100 << 16, 64'h70, w, rs, lat, gc);
      chk("hold_res", rs, 1);
      chk("hold_lat", lat, WIDTH + 3);

      // late arrival fairness
      run_job(4'b1000, rand_data(), 64'd0, w, rs, lat, gc);
      chk("late_first", w, 3);
      run_job(4'b1010, rand_data(), 64'd0, w, rs, lat, gc);
      chk("late_second", w, 1);
      run_job(4'b1010, rand_data(), 64'd0, w, rs, lat, gc);
      chk("late_third", w, 3);

      // reset during the 5th SHIFT cycle
      req = 4'b0001; data = rand_data(); hold = 1'b0;
      @(negedge clk);
      tick();
      for (int c = 0; c < 5; c++) begin
         if (c == 4) rst = 1'b1;
         @(negedge clk);
         tick();
      end
      rst = 1'b0; req = '0;
      @(negedge clk);
      chk("midrst_outs", {gnt, busy, ser_vld, ser_bit, done, done_id, div3, residue}, 0);
      tick();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("midrst_nodone", {done, busy}, 0);
         tick();
      end
      ptr_m = NREQ - 1;
      run_job(4'b0110, rand_data(), 64'd0, w, rs, lat, gc);
      chk("midrst_first", w, 1);

      // randomized jobs against the reference model
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) begin
            req = '0;
            @(negedge clk);
            chk("rnd_idle", {busy, gnt}, 0);
            tick();
         end
         hp = '0;
         for (int b = 0; b < 64; b++) hp[b] = ($urandom_range(0, 3) == 0);
         run_job(NREQ'($urandom_range(1, 15)), rand_data(), hp, w, rs, lat, gc);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
